// File: rtl/uart_rx_buffer.sv
// Receive-side buffer behind the UART receiver: synchronises the frame-valid level,
// captures one entry per frame into a show-ahead FIFO and reports occupancy/error status.
module uart_rx_buffer #(
    parameter int DATA_WIDTH      = 8,
    parameter int DEPTH           = 16,
    parameter int DROP_PARITY_ERR = 0
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [DATA_WIDTH-1:0]   rx_data,
    input  logic                    rx_valid,
    input  logic                    rx_parity_err,
    output logic [DATA_WIDTH-1:0]   out_data,
    output logic                    out_perr,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [$clog2(DEPTH):0]  count,
    output logic                    overflow,
    output logic [7:0]              err_count,
    input  logic                    clear_status
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int EW = DATA_WIDTH + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
    localparam logic          DROP_EN  = (DROP_PARITY_ERR != 0);

    logic                  r_s1;
    logic                  r_s2;
    logic                  r_s3;
    logic [EW-1:0]         r_mem [DEPTH];
    logic [AW-1:0]         r_wr_ptr;
    logic [AW-1:0]         r_rd_ptr;
    logic [CW-1:0]         r_count;
    logic [DATA_WIDTH-1:0] r_out_data;
    logic                  r_out_perr;
    logic                  r_out_valid;
    logic                  r_overflow;
    logic [7:0]            r_err_count;

    logic                  w_push;
    logic                  w_store;
    logic                  w_pop;
    logic                  w_full;
    logic                  w_write;
    logic                  w_ovf_evt;
    logic                  w_err_evt;
    logic [AW-1:0]         w_rd_next;
    logic [CW-1:0]         w_count_next;
    logic [EW-1:0]         w_entry;
    logic [EW-1:0]         w_head;

    // Next-state decode for the FIFO and the head register.
    always_comb begin
        w_push    = r_s2 & ~r_s3;
        w_store   = w_push & ~(DROP_EN & rx_parity_err);
        w_pop     = r_out_valid & out_ready;
        w_full    = (r_count == FULL_CNT);
        w_write   = w_store & (~w_full | w_pop);
        w_ovf_evt = w_store & w_full & ~w_pop;
        w_err_evt = w_push & rx_parity_err;
        w_entry   = {rx_parity_err, rx_data};
        w_rd_next = w_pop ? (r_rd_ptr + AW'(1)) : r_rd_ptr;
        case ({w_write, w_pop})
            2'b10:   w_count_next = r_count + CW'(1);
            2'b01:   w_count_next = r_count - CW'(1);
            default: w_count_next = r_count;
        endcase
        // The slot being written is the new head only when it lands where the read pointer goes.
        if (w_write && (r_wr_ptr == w_rd_next)) begin
            w_head = w_entry;
        end else begin
            w_head = r_mem[w_rd_next];
        end
    end

    // FIFO storage; contents need no reset.
    always_ff @(posedge clk) begin
        if (w_write) begin
            r_mem[r_wr_ptr] <= w_entry;
        end
    end

    // Synchroniser, pointers, registered head and sticky status.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_s1        <= 1'b0;
            r_s2        <= 1'b0;
            r_s3        <= 1'b0;
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_count     <= '0;
            r_out_data  <= '0;
            r_out_perr  <= 1'b0;
            r_out_valid <= 1'b0;
            r_overflow  <= 1'b0;
            r_err_count <= 8'd0;
        end else begin
            r_s1        <= rx_valid;
            r_s2        <= r_s1;
            r_s3        <= r_s2;
            r_rd_ptr    <= w_rd_next;
            r_count     <= w_count_next;
            r_out_valid <= (w_count_next != CW'(0));
            if (w_write) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_count_next != CW'(0)) begin
                r_out_perr <= w_head[EW-1];
                r_out_data <= w_head[DATA_WIDTH-1:0];
            end
            if (w_ovf_evt) begin
                r_overflow <= 1'b1;
            end else if (clear_status) begin
                r_overflow <= 1'b0;
            end
            // A parity event in the same cycle as a clear leaves a count of one.
            if (w_err_evt) begin
                if (clear_status) begin
                    r_err_count <= 8'd1;
                end else if (r_err_count != 8'hFF) begin
                    r_err_count <= r_err_count + 8'd1;
                end
            end else if (clear_status) begin
                r_err_count <= 8'd0;
            end
        end
    end

    assign out_data  = r_out_data;
    assign out_perr  = r_out_perr;
    assign out_valid = r_out_valid;
    assign count     = r_count;
    assign overflow  = r_overflow;
    assign err_count = r_err_count;

endmodule

// File: tb/tb_uart_rx_buffer.sv
// Scoreboard bench for uart_rx_buffer: stimulus queues expected entries, a monitor
// checks every accepted head; directed checks cover latency, full, parity and reset.
module tb_uart_rx_buffer;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_parity_err;
    logic [7:0] out_data;
    logic       out_perr;
    logic       out_valid;
    logic       out_ready;
    logic [4:0] count;
    logic       overflow;
    logic [7:0] err_count;
    logic       clear_status;

    logic       drop_en;
    logic       w_valid_d;
    logic [7:0] d_out_data;
    logic       d_out_perr;
    logic       d_out_valid;
    logic [4:0] d_count;
    logic       d_overflow;
    logic [7:0] d_err_count;

    logic [8:0] exp_q[$];
    int n_total = 0;
    int n_pass  = 0;

    always #5 clk = ~clk;

    assign w_valid_d = rx_valid & drop_en;

    uart_rx_buffer #(.DATA_WIDTH(8), .DEPTH(16), .DROP_PARITY_ERR(0)) dut (
        .clk(clk), .rst(rst), .rx_data(rx_data), .rx_valid(rx_valid),
        .rx_parity_err(rx_parity_err), .out_data(out_data), .out_perr(out_perr),
        .out_valid(out_valid), .out_ready(out_ready), .count(count),
        .overflow(overflow), .err_count(err_count), .clear_status(clear_status)
    );

    uart_rx_buffer #(.DATA_WIDTH(8), .DEPTH(16), .DROP_PARITY_ERR(1)) dut_drop (
        .clk(clk), .rst(rst), .rx_data(rx_data), .rx_valid(w_valid_d),
        .rx_parity_err(rx_parity_err), .out_data(d_out_data), .out_perr(d_out_perr),
        .out_valid(d_out_valid), .out_ready(1'b1), .count(d_count),
        .overflow(d_overflow), .err_count(d_err_count), .clear_status(1'b0)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    // Monitor: every accepted head must match the oldest expected entry.
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_pop", {23'd0, out_perr, out_data}, 32'h1FF);
            end else begin
                chk("sb_head", {23'd0, out_perr, out_data}, {23'd0, exp_q.pop_front()});
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_frame(input logic [7:0] d, input logic p);
        rx_data       = d;
        rx_parity_err = p;
        rx_valid      = 1'b1;
        tick(4);
        rx_valid      = 1'b0;
        tick(3);
    endtask

    task automatic drain();
        out_ready = 1'b1;
        for (int i = 0; i < 100 && count != 5'd0; i++) tick(1);
        out_ready = 1'b0;
        chk("drain_count", {27'd0, count}, 32'd0);
        chk("sb_empty", exp_q.size(), 32'd0);
    endtask

    task automatic pulse_clear();
        clear_status = 1'b1;
        tick(1);
        clear_status = 1'b0;
    endtask

    initial begin
        rst = 1'b1; rx_data = 8'h00; rx_valid = 1'b0; rx_parity_err = 1'b0;
        out_ready = 1'b0; clear_status = 1'b0; drop_en = 1'b0;
        tick(3);
        chk("rst_count", {27'd0, count}, 32'd0);
        chk("rst_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_data", {24'd0, out_data}, 32'd0);
        chk("rst_perr", {31'd0, out_perr}, 32'd0);
        chk("rst_ovf", {31'd0, overflow}, 32'd0);
        chk("rst_err", {24'd0, err_count}, 32'd0);
        rst = 1'b0;
        tick(2);

        // Single frame, 40-cycle valid level, latency of two edges.
        rx_data = 8'hA5; rx_parity_err = 1'b0; rx_valid = 1'b1;
        exp_q.push_back({1'b0, 8'hA5});
        tick(1);
        chk("lat_k", {31'd0, out_valid}, 32'd0);
        tick(1);
        chk("lat_k1", {31'd0, out_valid}, 32'd0);
        tick(1);
        chk("lat_k2_valid", {31'd0, out_valid}, 32'd1);
        chk("lat_k2_data", {24'd0, out_data}, 32'hA5);
        chk("lat_k2_perr", {31'd0, out_perr}, 32'd0);
        chk("lat_k2_count", {27'd0, count}, 32'd1);
        tick(37);
        rx_valid = 1'b0;
        tick(4);
        chk("one_push", {27'd0, count}, 32'd1);
        out_ready = 1'b1;
        tick(1);
        out_ready = 1'b0;
        chk("pop_count", {27'd0, count}, 32'd0);
        chk("pop_valid", {31'd0, out_valid}, 32'd0);

        // Fill to 16, 17th frame overflows.
        for (int i = 0; i < 17; i++) begin
            if (i < 16) exp_q.push_back({1'b0, 8'(i)});
            send_frame(8'(i), 1'b0);
        end
        chk("full_count", {27'd0, count}, 32'd16);
        chk("full_ovf", {31'd0, overflow}, 32'd1);
        pulse_clear();
        chk("clr_ovf", {31'd0, overflow}, 32'd0);

        // Full with a pop on the write edge: count holds, no overflow.
        rx_data = 8'h55; rx_parity_err = 1'b0; rx_valid = 1'b1;
        exp_q.push_back({1'b0, 8'h55});
        tick(2);
        out_ready = 1'b1;
        tick(1);
        out_ready = 1'b0;
        chk("fullpop_count", {27'd0, count}, 32'd16);
        chk("fullpop_ovf", {31'd0, overflow}, 32'd0);
        tick(1);
        rx_valid = 1'b0;
        tick(3);
        drain();

        // Parity: stored on the keeping instance, dropped on the other.
        drop_en = 1'b1;
        exp_q.push_back({1'b1, 8'h3C});
        send_frame(8'h3C, 1'b1);
        drop_en = 1'b0;
        chk("par_count", {27'd0, count}, 32'd1);
        chk("par_data", {24'd0, out_data}, 32'h3C);
        chk("par_perr", {31'd0, out_perr}, 32'd1);
        chk("par_err", {24'd0, err_count}, 32'd1);
        chk("drop_count", {27'd0, d_count}, 32'd0);
        chk("drop_valid", {31'd0, d_out_valid}, 32'd0);
        chk("drop_err", {24'd0, d_err_count}, 32'd1);
        drain();

        // 300 parity-error frames with continuous draining saturate err_count.
        out_ready = 1'b1;
        for (int i = 0; i < 300; i++) begin
            exp_q.push_back({1'b1, 8'(i)});
            send_frame(8'(i), 1'b1);
        end
        out_ready = 1'b0;
        chk("sat_err", {24'd0, err_count}, 32'd255);
        chk("sat_count", {27'd0, count}, 32'd0);
        chk("sat_sb", exp_q.size(), 32'd0);
        pulse_clear();
        chk("clr_err", {24'd0, err_count}, 32'd0);
        chk("clr_ovf2", {31'd0, overflow}, 32'd0);

        // Asynchronous reset in the middle of a drain with five entries held.
        for (int i = 0; i < 5; i++) send_frame(8'hE0 + 8'(i), 1'b0);
        chk("pre_rst_count", {27'd0, count}, 32'd5);
        out_ready = 1'b1;
        #1 rst = 1'b1;
        #1;
        chk("arst_count", {27'd0, count}, 32'd0);
        chk("arst_valid", {31'd0, out_valid}, 32'd0);
        chk("arst_ovf", {31'd0, overflow}, 32'd0);
        out_ready = 1'b0;
        tick(2);
        rst = 1'b0;
        tick(1);
        exp_q.push_back({1'b0, 8'h77});
        send_frame(8'h77, 1'b0);
        chk("post_rst_count", {27'd0, count}, 32'd1);
        chk("post_rst_data", {24'd0, out_data}, 32'h77);
        drain();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
